// File: rtl/mux16_rr_arbiter_if.sv
// Handshake/bus bundle between requesters and the mux16 round-robin arbiter.
// master drives requests/data; slave is the arbiter that drives select, grant and status.
interface mux16_rr_arbiter_if;
    logic [15:0] req;
    logic        done;
    logic [15:0] data_in;
    logic [3:0]  sel;
    logic [15:0] gnt;
    logic        busy;
    logic        data_out;
    logic        timeout;

    modport master (
        output req, done, data_in,
        input  sel, gnt, busy, data_out, timeout
    );

    modport slave (
        input  req, done, data_in,
        output sel, gnt, busy, data_out, timeout
    );
endinterface

// File: rtl/mux16_rr_arbiter.sv
// Round-robin select controller for a shared 16:1 single-bit mux.
// Define MUX16_ARB_TIMEOUT_EN to force-release a grant after MAX_HOLD cycles.
module mux16_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               rst,
    mux16_rr_arbiter_if.slave  bus
);

    typedef enum logic {IDLE, GRANT} state_t;

    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("MAX_HOLD must be in 1..255");
    end

    state_t      state_q, state_d;
    logic [3:0]  ptr_q, ptr_d;
    logic [3:0]  sel_q, sel_d;
    logic [15:0] gnt_q, gnt_d;
    logic        busy_q, busy_d;
    logic        timeout_q, timeout_d;

    // Requests rotated so that bit 0 is the current highest-priority slot.
    logic [15:0] req_rot;
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_rot
            assign req_rot[gi] = bus.req[ptr_q + 4'(gi)];
        end
    endgenerate

    logic       found;
    logic [3:0] offset;
    logic [3:0] winner;

    always_comb begin
        found  = 1'b0;
        offset = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (req_rot[i]) begin
                found  = 1'b1;
                offset = 4'(i);
            end
        end
        winner = ptr_q + offset;
    end

    logic owner_req;
    logic release_now;
    logic forced;
    assign owner_req = bus.req[sel_q];

`ifdef MUX16_ARB_TIMEOUT_EN
    logic [7:0] hold_q, hold_d;
    logic       hold_hit;
    assign hold_hit    = (hold_q == 8'(MAX_HOLD));
    assign forced      = hold_hit && !bus.done && owner_req;
    assign release_now = bus.done || !owner_req || hold_hit;
`else
    assign forced      = 1'b0;
    assign release_now = bus.done || !owner_req;
`endif

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        gnt_d     = gnt_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;
`ifdef MUX16_ARB_TIMEOUT_EN
        hold_d    = hold_q;
`endif
        if (state_q == GRANT && !release_now) begin
`ifdef MUX16_ARB_TIMEOUT_EN
            hold_d = (hold_q == 8'hFF) ? hold_q : hold_q + 8'd1;
`endif
        end else if (found) begin
            // Fresh grant from IDLE, or same-edge handover with no bubble.
            state_d   = GRANT;
            sel_d     = winner;
            gnt_d     = 16'd1 << winner;
            busy_d    = 1'b1;
            ptr_d     = winner + 4'd1;
            timeout_d = forced;
`ifdef MUX16_ARB_TIMEOUT_EN
            hold_d    = 8'd1;
`endif
        end else begin
            state_d = IDLE;
            gnt_d   = 16'd0;
            busy_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= 4'd0;
            sel_q     <= 4'd0;
            gnt_q     <= 16'd0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
`ifdef MUX16_ARB_TIMEOUT_EN
            hold_q    <= 8'd0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            sel_q     <= sel_d;
            gnt_q     <= gnt_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
`ifdef MUX16_ARB_TIMEOUT_EN
            hold_q    <= hold_d;
`endif
        end
    end

    assign bus.sel      = sel_q;
    assign bus.gnt      = gnt_q;
    assign bus.busy     = busy_q;
    assign bus.timeout  = timeout_q;
    assign bus.data_out = busy_q & bus.data_in[sel_q];

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Directed self-checking bench for mux16_rr_arbiter (honours MUX16_ARB_TIMEOUT_EN).
module tb_mux16_rr_arbiter;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    mux16_rr_arbiter_if bus ();

    mux16_rr_arbiter #(.MAX_HOLD(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic show(input string tag);
        $display("%0t %s req=%h done=%b sel=%0d gnt=%h busy=%b dout=%b to=%b",
                 $time, tag, bus.req, bus.done, bus.sel, bus.gnt, bus.busy,
                 bus.data_out, bus.timeout);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #3;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req = 16'h0; bus.done = 1'b0; bus.data_in = 16'hFFFF;
        step();
        step();
        show("reset");
        vectors++;
        if ({bus.sel, bus.gnt, bus.busy, bus.timeout, bus.data_out} !== 23'd0) begin
            $display("FAIL reset_state: got sel=%0d gnt=%h busy=%b to=%b dout=%b expected all 0",
                     bus.sel, bus.gnt, bus.busy, bus.timeout, bus.data_out);
            miscompares++;
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        bus.req = 16'h0010; bus.data_in = 16'h0010;
        step();
        show("single");
        vectors++;
        if (bus.sel !== 4'd4 || bus.gnt !== 16'h0010 || bus.busy !== 1'b1) begin
            $display("FAIL single_grant: got sel=%0d gnt=%h busy=%b expected sel=4 gnt=0010 busy=1",
                     bus.sel, bus.gnt, bus.busy);
            miscompares++;
        end
        vectors++;
        if (bus.data_out !== 1'b1) begin
            $display("FAIL single_dout1: got %b expected 1", bus.data_out);
            miscompares++;
        end
        bus.data_in = 16'h0000;
        #1;
        vectors++;
        if (bus.data_out !== 1'b0) begin
            $display("FAIL single_dout0: got %b expected 0", bus.data_out);
            miscompares++;
        end
        bus.req = 16'h0; bus.data_in = 16'hFFFF;
        step();
        show("single_rel");
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_sel [6];
        exp_sel = '{4'd0, 4'd1, 4'd15, 4'd0, 4'd1, 4'd15};
        do_reset();
        bus.req = 16'h8003; bus.done = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            show("rr");
            vectors++;
            if (bus.sel !== exp_sel[i] || bus.gnt !== (16'd1 << exp_sel[i]) || bus.busy !== 1'b1) begin
                $display("FAIL rr_order[%0d]: got sel=%0d gnt=%h busy=%b expected sel=%0d busy=1",
                         i, bus.sel, bus.gnt, bus.busy, exp_sel[i]);
                miscompares++;
            end
        end
        bus.req = 16'h0; bus.done = 1'b0;
        step();
    endtask

    task automatic test_wrap_self();
        do_reset();
        bus.req = 16'h8000; bus.done = 1'b1; bus.data_in = 16'h8000;
        for (int i = 0; i < 4; i++) begin
            step();
            show("wrap");
            vectors++;
            if (bus.sel !== 4'd15 || bus.gnt !== 16'h8000 || bus.busy !== 1'b1 || bus.data_out !== 1'b1) begin
                $display("FAIL wrap_regrant[%0d]: got sel=%0d gnt=%h busy=%b dout=%b expected sel=15 gnt=8000 busy=1 dout=1",
                         i, bus.sel, bus.gnt, bus.busy, bus.data_out);
                miscompares++;
            end
        end
        // ptr has wrapped to 0: requester 0 now beats requester 14.
        bus.req = 16'h4001; bus.done = 1'b1;
        step();
        show("wrap_ptr");
        vectors++;
        if (bus.sel !== 4'd0) begin
            $display("FAIL wrap_ptr: got sel=%0d expected 0", bus.sel);
            miscompares++;
        end
        bus.req = 16'h0; bus.done = 1'b0;
        step();
    endtask

    task automatic test_release_idle();
        do_reset();
        bus.req = 16'h0008; bus.data_in = 16'hFFFF;
        step();
        bus.req = 16'h000C;
        step();
        step();
        show("hold3");
        vectors++;
        if (bus.sel !== 4'd3 || bus.gnt !== 16'h0008) begin
            $display("FAIL no_preempt: got sel=%0d gnt=%h expected sel=3 gnt=0008", bus.sel, bus.gnt);
            miscompares++;
        end
        bus.req = 16'h0;
        step();
        show("idle");
        vectors++;
        if (bus.gnt !== 16'h0 || bus.busy !== 1'b0 || bus.data_out !== 1'b0 || bus.sel !== 4'd3) begin
            $display("FAIL release_idle: got sel=%0d gnt=%h busy=%b dout=%b expected sel=3 gnt=0 busy=0 dout=0",
                     bus.sel, bus.gnt, bus.busy, bus.data_out);
            miscompares++;
        end
        bus.done = 1'b1;
        step();
        show("done_idle");
        vectors++;
        if (bus.busy !== 1'b0 || bus.gnt !== 16'h0) begin
            $display("FAIL done_idle: got busy=%b gnt=%h expected busy=0 gnt=0", bus.busy, bus.gnt);
            miscompares++;
        end
        bus.done = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.req = 16'h0080;
        step();
        step();
        vectors++;
        if (bus.sel !== 4'd7 || bus.busy !== 1'b1) begin
            $display("FAIL async_pre: got sel=%0d busy=%b expected sel=7 busy=1", bus.sel, bus.busy);
            miscompares++;
        end
        #2;
        rst = 1'b1;
        #1;
        show("async_rst");
        vectors++;
        if (bus.gnt !== 16'h0 || bus.busy !== 1'b0 || bus.sel !== 4'd0) begin
            $display("FAIL async_reset: got sel=%0d gnt=%h busy=%b expected sel=0 gnt=0 busy=0",
                     bus.sel, bus.gnt, bus.busy);
            miscompares++;
        end
        bus.req = 16'h0180;
        #2;
        rst = 1'b0;
        step();
        show("post_rst");
        vectors++;
        if (bus.sel !== 4'd7 || bus.gnt !== 16'h0080) begin
            $display("FAIL post_reset_grant: got sel=%0d gnt=%h expected sel=7 gnt=0080", bus.sel, bus.gnt);
            miscompares++;
        end
        bus.req = 16'h0;
        step();
    endtask

    task automatic test_hold_limit();
        logic [3:0] exp_sel;
        logic       exp_to;
        do_reset();
        bus.req = 16'h0003; bus.done = 1'b0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            step();
`ifdef MUX16_ARB_TIMEOUT_EN
            exp_sel = 4'(((cyc - 1) / 8) % 2);
            exp_to  = (cyc > 1) && ((cyc - 1) % 8 == 0);
`else
            exp_sel = 4'd0;
            exp_to  = 1'b0;
`endif
            show("hold");
            vectors++;
            if (bus.sel !== exp_sel || bus.timeout !== exp_to || bus.busy !== 1'b1) begin
                $display("FAIL hold_limit[%0d]: got sel=%0d to=%b busy=%b expected sel=%0d to=%b busy=1",
                         cyc, bus.sel, bus.timeout, bus.busy, exp_sel, exp_to);
                miscompares++;
            end
        end
        bus.req = 16'h0;
        step();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        bus.req     = 16'h0;
        bus.done    = 1'b0;
        bus.data_in = 16'h0;
        test_reset();
        test_single();
        test_round_robin();
        test_wrap_self();
        test_release_idle();
        test_async_reset();
        test_hold_limit();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
